// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//   Multi-cycle fetch/decode/execute control unit for the 6-bit-PC datapath.
//   Fetches a 16-bit instruction over a valid-qualified memory port, latches
//   it in IR, and drives register-file selects, ALU function, register write
//   enable and the program-counter select.
//
// Ports
//   clk_main_i    system clock, all state on rising edge
//   reset_i       synchronous, active-high reset
//   imem_req_o    fetch request, high for the whole FETCH state
//   imem_valid_i  imem_rdata_i valid this cycle
//   imem_rdata_i  instruction word
//   flag_z_i      ALU zero flag, used in EXECUTE of BZ
//   flag_n_i      ALU negative flag, used in EXECUTE of BN
//   ir_o          instruction register
//   DA_o/SA_o/SB_o  register selects, continuous slices of IR
//   alu_fs_o      ALU function (opcode) in EXECUTE of an ALU op, else 0
//   reg_we_o      register write pulse (EXECUTE of an ALU op only)
//   PS_o          PC select: 00 hold, 01 inc, 10 branch {SA,SB}, 11 jump to A
//   halted_o      in HALT state
//   fault_o       sticky: fetch timeout or illegal opcode
//   instr_cnt_o   retired-instruction count, saturating
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int IW        = 16,
  parameter int FETCH_TMO = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk_main_i,
  input  logic             reset_i,
  output logic             imem_req_o,
  input  logic             imem_valid_i,
  input  logic [IW-1:0]    imem_rdata_i,
  input  logic             flag_z_i,
  input  logic             flag_n_i,
  output logic [IW-1:0]    ir_o,
  output logic [3:0]       DA_o,
  output logic [3:0]       SA_o,
  output logic [3:0]       SB_o,
  output logic [3:0]       alu_fs_o,
  output logic             reg_we_o,
  output logic [1:0]       PS_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int TMO_W = $clog2(FETCH_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BN   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [3:0] op;
  logic       op_alu;
  logic       op_illegal;

  assign op         = ir_q[15:12];
  assign op_alu     = (op >= 4'h1) && (op <= 4'h7);
  assign op_illegal = (op >= 4'hB) && (op <= 4'hE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d   = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_valid_i) begin
          ir_d    = imem_rdata_i;
          tmo_d   = '0;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          // FETCH_TMO consecutive fetch cycles without data
          fault_d = 1'b1;
          tmo_d   = '0;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        if (cnt_q != {CNT_W{1'b1}})
          cnt_d = cnt_q + 1'b1;
        if (op_illegal)
          fault_d = 1'b1;
        state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_main_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs decoded from registered state and IR. The only input path
  // is the branch flags into PS, since they are sampled during EXECUTE itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_fs_o = 4'h0;
    reg_we_o = 1'b0;
    PS_o     = PS_HOLD;
    if (state_q == S_EXEC) begin
      if (op_alu) begin
        alu_fs_o = op;
        reg_we_o = 1'b1;
        PS_o     = PS_INC;
      end else begin
        unique case (op)
          OP_NOP:  PS_o = PS_INC;
          OP_BZ:   PS_o = flag_z_i ? PS_BR : PS_INC;
          OP_BN:   PS_o = flag_n_i ? PS_BR : PS_INC;
          OP_JMP:  PS_o = PS_JMP;
          OP_HALT: PS_o = PS_HOLD;
          default: PS_o = PS_INC;   // illegal opcodes retire as NOP
        endcase
      end
    end
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign halted_o    = (state_q == S_HALT);
  assign fault_o     = fault_q;
  assign instr_cnt_o = cnt_q;
  assign ir_o        = ir_q;
  assign DA_o        = ir_q[11:8];
  assign SA_o        = ir_q[7:4];
  assign SB_o        = ir_q[3:0];

endmodule

// File: tb/tb_instruction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_sequencer
//   Directed stimulus with hand-computed expectations. Each instruction pushes
//   its expected EXECUTE response into a queue; an independent monitor pops
//   and compares whenever the DUT shows a PS or reg_we pulse.
// -----------------------------------------------------------------------------
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        flag_z, flag_n;
  logic [15:0] ir;
  logic [3:0]  da, sa, sb, alu_fs;
  logic        reg_we;
  logic [1:0]  ps;
  logic        halted, fault;
  logic [15:0] instr_cnt;

  always #5 clk = ~clk;

  instruction_sequencer #(.IW(16), .FETCH_TMO(15), .CNT_W(16)) dut (
    .clk_main_i  (clk),
    .reset_i     (reset),
    .imem_req_o  (imem_req),
    .imem_valid_i(imem_valid),
    .imem_rdata_i(imem_rdata),
    .flag_z_i    (flag_z),
    .flag_n_i    (flag_n),
    .ir_o        (ir),
    .DA_o        (da),
    .SA_o        (sa),
    .SB_o        (sb),
    .alu_fs_o    (alu_fs),
    .reg_we_o    (reg_we),
    .PS_o        (ps),
    .halted_o    (halted),
    .fault_o     (fault),
    .instr_cnt_o (instr_cnt)
  );

  typedef struct packed {
    logic [1:0]  ps;
    logic        we;
    logic [3:0]  fs;
    logic [3:0]  da;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every PS/reg_we pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (reset === 1'b0 && (ps !== 2'b00 || reg_we !== 1'b0)) begin
      a = {ps, reg_we, alu_fs, da, sa, sb, instr_cnt};
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got ps=%0h we=%0b with no instruction expected", ps, reg_we);
      end else begin
        e = q.pop_front();
        chk("exec_response", 64'(a), 64'(e));
      end
    end
  end

  task automatic push(input logic [1:0] p, input logic w, input logic [3:0] f,
                      input logic [3:0] d, input logic [3:0] s_a, input logic [3:0] s_b);
    exp_t e;
    e = '{ps: p, we: w, fs: f, da: d, sa: s_a, sb: s_b, cnt: exp_cnt};
    q.push_back(e);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  // One-cycle synchronous reset; returns at the negedge after it was sampled.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_reg_we"},   64'(reg_we),   64'd0);
    chk({tag, "_ps"},       64'(ps),       64'd0);
    chk({tag, "_alu_fs"},   64'(alu_fs),   64'd0);
    chk({tag, "_halted"},   64'(halted),   64'd0);
    chk({tag, "_fault"},    64'(fault),    64'd0);
    chk({tag, "_cnt"},      64'(instr_cnt), 64'd0);
    chk({tag, "_ir"},       64'(ir),       64'd0);
  endtask

  // Waits for FETCH, withholds valid for dly cycles, then delivers w.
  // Returns at the DECODE negedge; reqc = fetch cycles observed.
  task automatic fetch(input logic [15:0] w, input int dly, output int reqc);
    int g;
    g = 0;
    reqc = 0;
    while (imem_req !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (imem_req !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_wait: imem_req not seen within 40 cycles");
      return;
    end
    repeat (dly) begin
      if (imem_req === 1'b1) reqc++;
      @(negedge clk);
    end
    if (imem_req === 1'b1) reqc++;
    imem_valid = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
  endtask

  initial begin
    int c;
    reset      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
    flag_z     = 1'b0;
    flag_n     = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset values, fetch starts one cycle later, ALU op 0x1234
    do_reset();
    chk_reset_vals("t1_reset");
    @(negedge clk);
    chk("t1_req_after_reset", 64'(imem_req), 64'd1);
    push(2'b01, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
    fetch(16'h1234, 0, c);
    chk("t1_req_cycles", 64'(c), 64'd1);
    chk("t1_decode_we", 64'(reg_we), 64'd0);
    @(negedge clk);               // EXECUTE, monitor checks
    @(negedge clk);
    chk("t1_cnt", 64'(instr_cnt), 64'd1);

    // 2: BZ taken then not taken
    flag_z = 1'b1;
    push(2'b10, 1'b0, 4'h0, 4'h0, 4'h1, 4'h2);
    fetch(16'h8012, 0, c);
    @(negedge clk);
    chk("t2_bz_taken_we", 64'(reg_we), 64'd0);
    @(negedge clk);
    chk("t2_ps_after", 64'(ps), 64'd0);
    flag_z = 1'b0;
    push(2'b01, 1'b0, 4'h0, 4'h0, 4'h1, 4'h2);
    fetch(16'h8012, 0, c);
    @(negedge clk);
    chk("t2_bz_nt_we", 64'(reg_we), 64'd0);
    @(negedge clk);

    // 3: JMP with valid delayed 5 cycles
    push(2'b11, 1'b0, 4'h0, 4'h0, 4'h5, 4'h0);
    fetch(16'hA050, 5, c);
    chk("t3_req_cycles", 64'(c), 64'd6);
    @(negedge clk);
    @(negedge clk);
    chk("t3_cnt", 64'(instr_cnt), 64'd4);

    // 4: fetch timeout, then illegal opcode after reset
    do_reset();
    @(negedge clk);
    c = 0;
    while (imem_req === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk("t4_tmo_cycles", 64'(c), 64'd15);
    chk("t4_fault", 64'(fault), 64'd1);
    chk("t4_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_halt_ps", 64'(ps), 64'd0);
    end
    do_reset();
    chk("t4_fault_cleared", 64'(fault), 64'd0);
    push(2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    fetch(16'hC000, 0, c);
    @(negedge clk);
    @(negedge clk);
    chk("t4_illegal_fault", 64'(fault), 64'd1);
    chk("t4_illegal_cnt", 64'(instr_cnt), 64'd1);
    chk("t4_not_halted", 64'(halted), 64'd0);

    // 5: HALT, then reset restarts fetch
    fetch(16'hF000, 0, c);
    @(negedge clk);
    chk("t5_exec_ps", 64'(ps), 64'd0);
    @(negedge clk);
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_cnt", 64'(instr_cnt), 64'd2);
    repeat (4) @(negedge clk);
    chk("t5_still_halted", 64'(halted), 64'd1);
    chk("t5_halt_req", 64'(imem_req), 64'd0);
    do_reset();
    chk_reset_vals("t5_reset");
    @(negedge clk);
    chk("t5_req_restart", 64'(imem_req), 64'd1);

    // 6: reset during DECODE of an ALU op aborts it
    fetch(16'h1234, 0, c);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_we", 64'(reg_we), 64'd0);
    chk("t6_ps", 64'(ps), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_cnt", 64'(instr_cnt), 64'd0);
    chk("t6_ir", 64'(ir), 64'd0);

    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
